// File: rtl/hram_traffic_checker.sv
// HyperRAM Avalon-MM traffic checker: write a pattern window, read back, compare.
// Define HRAM_TG_LFSR_EN to use a Galois LFSR pattern instead of address^seed.
module hram_traffic_checker #(
  parameter int ADDR_W    = 22,
  parameter int DATA_W    = 16,
  parameter int BASE_ADDR = 0,
  parameter int NUM_WORDS = 256,
  parameter int ERR_CNT_W = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_write,
  output logic                  avm_read,
  output logic [DATA_W-1:0]     avm_writedata,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  input  logic                  avm_waitrequest,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_readdatavalid
);

  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_REQ,
    S_RD_WAIT,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_W-1:0]      seed_q, seed_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [ERR_CNT_W-1:0]   err_q, err_d;
  logic [ADDR_W-1:0]      ferr_q, ferr_d;
  logic                   pass_q, pass_d;

  logic [ADDR_W-1:0]      addr;
  logic [DATA_W-1:0]      pat;
  logic                   last;
  logic                   tmo_hit;

  assign addr = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
  assign last = (idx_q == IW'(NUM_WORDS - 1));
  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

`ifdef HRAM_TG_LFSR_EN
  localparam logic [63:0] TAPS =
    (DATA_W == 8)  ? 64'h00000000000000B8 :
    (DATA_W == 16) ? 64'h000000000000B400 :
    (DATA_W == 24) ? 64'h0000000000E10000 :
    (DATA_W == 32) ? 64'h0000000080200003 :
    (DATA_W == 64) ? 64'hD800000000000000 :
                     64'h0000000000000000;
  localparam logic [DATA_W-1:0] MASK = TAPS[DATA_W-1:0];

  logic [DATA_W-1:0] pat_q, pat_d;
  logic [DATA_W-1:0] pat_nxt;

  function automatic logic [DATA_W-1:0] seed_fix(
    input logic [DATA_W-1:0] s
  );
    return (s == '0) ? DATA_W'(1) : s;
  endfunction

  assign pat     = pat_q;
  assign pat_nxt = pat_q[0] ? ((pat_q >> 1) ^ MASK)
                            : (pat_q >> 1);
`else
  assign pat = DATA_W'(addr) ^ seed_q;
`endif

  assign avm_byteenable = '1;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    seed_d        = seed_q;
    tmo_d         = tmo_q;
    err_d         = err_q;
    ferr_d        = ferr_q;
    pass_d        = pass_q;
`ifdef HRAM_TG_LFSR_EN
    pat_d         = pat_q;
`endif
    busy          = 1'b0;
    done          = 1'b0;
    avm_write     = 1'b0;
    avm_read      = 1'b0;
    avm_address   = '0;
    avm_writedata = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WR;
          idx_d   = '0;
          seed_d  = seed;
          err_d   = '0;
          ferr_d  = '0;
          pass_d  = 1'b0;
`ifdef HRAM_TG_LFSR_EN
          pat_d   = seed_fix(seed);
`endif
        end
      end
      S_WR: begin
        busy          = 1'b1;
        avm_write     = 1'b1;
        avm_address   = addr;
        avm_writedata = pat;
        if (!avm_waitrequest) begin
`ifdef HRAM_TG_LFSR_EN
          pat_d = last ? seed_fix(seed_q) : pat_nxt;
`endif
          if (last) begin
            idx_d   = '0;
            state_d = S_RD_REQ;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_RD_REQ: begin
        busy        = 1'b1;
        avm_read    = 1'b1;
        avm_address = addr;
        if (!avm_waitrequest) begin
          state_d = S_RD_WAIT;
          tmo_d   = '0;
        end
      end
      S_RD_WAIT: begin
        busy        = 1'b1;
        avm_address = addr;
        if (avm_readdatavalid || tmo_hit) begin
          // Late data on the timeout cycle still counts as data.
          if (!avm_readdatavalid || (avm_readdata != pat)) begin
            if (err_q != '1) err_d = err_q + ERR_CNT_W'(1);
            if (err_q == '0) ferr_d = addr;
          end
`ifdef HRAM_TG_LFSR_EN
          pat_d = pat_nxt;
`endif
          if (last) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_RD_REQ;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DONE: begin
        done    = 1'b1;
        pass_d  = (err_q == '0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      seed_q  <= '0;
      tmo_q   <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      pass_q  <= 1'b0;
`ifdef HRAM_TG_LFSR_EN
      pat_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seed_q  <= seed_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      pass_q  <= pass_d;
`ifdef HRAM_TG_LFSR_EN
      pat_q   <= pat_d;
`endif
    end
  end

endmodule

// File: tb/tb_hram_traffic_checker.sv
// Directed bench for hram_traffic_checker: main 256-word window plus a
// wrapping 8-word window at the top of the address space.
module tb_hram_traffic_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] seed = '0;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [21:0] ferr;
  logic [21:0] addr;
  logic        wr, rd;
  logic [15:0] wdata;
  logic [1:0]  be;
  logic        wait_r = 1'b0;
  logic [15:0] rdata = '0;
  logic        rdv = 1'b0;

  logic        start2 = 1'b0;
  logic [15:0] seed2 = '0;
  logic        busy2, done2, pass2;
  logic [15:0] err2;
  logic [21:0] ferr2;
  logic [21:0] addr2;
  logic        wr2, rd2;
  logic [15:0] wdata2;
  logic [1:0]  be2;
  logic        wait2 = 1'b0;
  logic [15:0] rdata2 = '0;
  logic        rdv2 = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hram_traffic_checker dut (
    .clock(clk), .reset_n(rst_n), .start(start), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(ferr), .avm_address(addr), .avm_write(wr),
    .avm_read(rd), .avm_writedata(wdata), .avm_byteenable(be),
    .avm_waitrequest(wait_r), .avm_readdata(rdata),
    .avm_readdatavalid(rdv)
  );

  hram_traffic_checker #(.BASE_ADDR(4194300), .NUM_WORDS(8)) dut2 (
    .clock(clk), .reset_n(rst_n), .start(start2), .seed(seed2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_err_addr(ferr2), .avm_address(addr2), .avm_write(wr2),
    .avm_read(rd2), .avm_writedata(wdata2), .avm_byteenable(be2),
    .avm_waitrequest(wait2), .avm_readdata(rdata2),
    .avm_readdatavalid(rdv2)
  );

  // Slave for dut: optional random stall, read latency 3, fault injection.
  logic [15:0] mem [0:255];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          stall_viol = 0;
  bit          wait_rand = 0;
  int          flip_addr = -1;
  int          drop_addr = -1;
  int          pend = 0;
  logic [15:0] pdata = '0;
  bit          prev_stall = 0;
  logic [21:0] prev_addr = '0;
  logic [15:0] prev_wdata = '0;

  always @(negedge clk) begin
    if (prev_stall && (!wr || addr !== prev_addr || wdata !== prev_wdata))
      stall_viol++;
    rdv = 1'b0;
    if (!rst_n) pend = 0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        rdv   = 1'b1;
        rdata = pdata;
      end
    end
    wait_r = wait_rand ? ($urandom_range(1, 0) == 1) : 1'b0;
    prev_stall = wr && wait_r;
    prev_addr  = addr;
    prev_wdata = wdata;
    if (wr && !wait_r) begin
      mem[addr[7:0]] = wdata;
      wr_cnt++;
    end
    if (rd && !wait_r) begin
      rd_cnt++;
      if (int'(addr) != drop_addr) begin
        pend  = 3;
        pdata = mem[addr[7:0]] ^
                ((int'(addr) == flip_addr) ? 16'h0001 : 16'h0000);
      end
    end
  end

  // Slave for dut2: no stall, read latency 1, logs write traffic.
  logic [15:0] mem2 [0:7];
  logic [21:0] wa_q [$];
  logic [15:0] wd_q [$];
  bit          pend2 = 0;
  logic [15:0] pd2 = '0;

  always @(negedge clk) begin
    rdv2 = 1'b0;
    if (pend2) begin
      rdv2   = 1'b1;
      rdata2 = pd2;
      pend2  = 0;
    end
    if (wr2) begin
      mem2[addr2[2:0]] = wdata2;
      wa_q.push_back(addr2);
      wd_q.push_back(wdata2);
    end
    if (rd2) begin
      pend2 = 1;
      pd2   = mem2[addr2[2:0]];
    end
  end

  task automatic run_pass(input logic [15:0] s, output bit ok);
    @(negedge clk);
    wr_cnt = 0;
    rd_cnt = 0;
    seed   = s;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, pass, wr, rd} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b exp 00000", {busy, done, pass, wr, rd});
    end
    checks++;
    if (err_count !== 16'h0 || ferr !== 22'h0) begin
      errors++;
      $display("FAIL reset_err: got %h/%h exp 0/0", err_count, ferr);
    end
    checks++;
    if (addr !== 22'h0 || wdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_bus: got %h/%h exp 0/0", addr, wdata);
    end
    checks++;
    if (be !== 2'b11) begin
      errors++;
      $display("FAIL byteenable: got %b exp 11", be);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ideal;
    bit ok;
    run_pass(16'h0000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ideal_done: got no done exp done");
    end
    checks++;
    if (pass !== 1'b1 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL ideal_pass: got %b/%0d exp 1/0", pass, err_count);
    end
    checks++;
    if (wr_cnt != 256 || rd_cnt != 256) begin
      errors++;
      $display("FAIL ideal_count: got %0d/%0d exp 256/256", wr_cnt, rd_cnt);
    end
  endtask

  task automatic test_bit_flip;
    bit ok;
    flip_addr = 5;
    run_pass(16'h1234, ok);
    flip_addr = -1;
    checks++;
    if (!ok || pass !== 1'b0) begin
      errors++;
      $display("FAIL flip_pass: got done=%b pass=%b exp 1/0", ok, pass);
    end
    checks++;
    if (err_count !== 16'd1 || ferr !== 22'h5) begin
      errors++;
      $display("FAIL flip_err: got %0d/%h exp 1/5", err_count, ferr);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    @(negedge clk);
    seed  = 16'h0F0F;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (wr !== 1'b1) begin
      errors++;
      $display("FAIL mid_in_wr: got %b exp 1", wr);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, pass, wr, rd} !== 5'b0 || addr !== 22'h0 ||
        wdata !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset_bus: got %b %h %h exp 0 0 0",
               {busy, done, pass, wr, rd}, addr, wdata);
    end
    checks++;
    if (err_count !== 16'h0 || ferr !== 22'h0) begin
      errors++;
      $display("FAIL mid_reset_err: got %h/%h exp 0/0", err_count, ferr);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rd !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle: got busy=%b rd=%b exp 0/0", busy, rd);
    end
    run_pass(16'h00FF, ok);
    checks++;
    if (!ok || pass !== 1'b1) begin
      errors++;
      $display("FAIL mid_recover: got %b/%b exp 1/1", ok, pass);
    end
  endtask

  task automatic test_waitreq;
    bit ok;
    stall_viol = 0;
    wait_rand  = 1;
    run_pass(16'hA5A5, ok);
    wait_rand = 0;
    checks++;
    if (!ok || pass !== 1'b1) begin
      errors++;
      $display("FAIL wait_pass: got %b/%b exp 1/1", ok, pass);
    end
    checks++;
    if (wr_cnt != 256 || rd_cnt != 256) begin
      errors++;
      $display("FAIL wait_count: got %0d/%0d exp 256/256", wr_cnt, rd_cnt);
    end
    checks++;
    if (stall_viol != 0) begin
      errors++;
      $display("FAIL wait_stable: got %0d exp 0", stall_viol);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    drop_addr = 16;
    run_pass(16'h0000, ok);
    drop_addr = -1;
    checks++;
    if (!ok || pass !== 1'b0) begin
      errors++;
      $display("FAIL tmo_pass: got %b/%b exp 1/0", ok, pass);
    end
    checks++;
    if (err_count !== 16'd1 || ferr !== 22'h10) begin
      errors++;
      $display("FAIL tmo_err: got %0d/%h exp 1/10", err_count, ferr);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    @(negedge clk);
    seed  = 16'h00AA;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (300) @(negedge clk);
    seed  = 16'h5555;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (!ok || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pulse: got seen=%b done=%b exp 1/0", ok, done);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_start_on_done: got busy=%b exp 0", busy);
    end
    checks++;
    if (pass !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy_start: got pass=%b exp 1", pass);
    end
  endtask

  task automatic test_pattern;
    bit ok;
    logic [15:0] exp [4];
    int          idx [4];
`ifdef HRAM_TG_LFSR_EN
    run_pass(16'h0001, ok);
    idx = '{0, 1, 2, 3};
    exp = '{16'h0001, 16'hB400, 16'h5A00, 16'h2D00};
`else
    run_pass(16'h1234, ok);
    idx = '{0, 5, 128, 255};
    exp = '{16'h1234, 16'h1231, 16'h12B4, 16'h12CB};
`endif
    checks++;
    if (!ok || pass !== 1'b1) begin
      errors++;
      $display("FAIL pat_pass: got %b/%b exp 1/1", ok, pass);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem[idx[k]] !== exp[k]) begin
        errors++;
        $display("FAIL pat_word%0d: got %h exp %h", idx[k], mem[idx[k]], exp[k]);
      end
    end
  endtask

  task automatic test_wrap;
    bit ok;
    logic [21:0] ea [8];
    logic [15:0] ed [8];
    ea = '{22'h3FFFFC, 22'h3FFFFD, 22'h3FFFFE, 22'h3FFFFF,
           22'h000000, 22'h000001, 22'h000002, 22'h000003};
`ifdef HRAM_TG_LFSR_EN
    ed = '{16'h0001, 16'hB400, 16'h5A00, 16'h2D00,
           16'h1680, 16'h0B40, 16'h05A0, 16'h02D0};
`else
    ed = '{16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF,
           16'h0000, 16'h0001, 16'h0002, 16'h0003};
`endif
    wa_q.delete();
    wd_q.delete();
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    ok = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (done2) begin
        ok = 1;
        break;
      end
    end
    @(negedge clk);
    checks++;
    if (!ok || pass2 !== 1'b1 || err2 !== 16'd0) begin
      errors++;
      $display("FAIL wrap_pass: got %b/%b/%0d exp 1/1/0", ok, pass2, err2);
    end
    checks++;
    if (wa_q.size() != 8) begin
      errors++;
      $display("FAIL wrap_count: got %0d exp 8", wa_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (wa_q[k] !== ea[k] || wd_q[k] !== ed[k]) begin
          errors++;
          $display("FAIL wrap_word%0d: got %h/%h exp %h/%h",
                   k, wa_q[k], wd_q[k], ea[k], ed[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_bit_flip();
    test_reset_mid();
    test_waitreq();
    test_timeout();
    test_back_to_back();
    test_pattern();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
